// File: rtl/edge_det_stream_if.sv
// rtl/edge_det_stream_if.sv - pixel stream and control bundle for edge_det_stream
//
// Purpose: groups the input pixel stream, the quasi-static controls and the
// output stream of the edge detector into one bundle.
// Signals:
//   in_valid  pixel qualifier          in_sof   start of frame (with in_valid)
//   in_rgb    {R,G,B} input pixel      mode     00 |Gx|+|Gy|, 01 |Gx|, 10 |Gy|, 11 luma
//   thresh    noise floor              out_valid output qualifier
//   out_sof   delayed in_sof           out_edge edge/luma result
//   out_rgb   window-centre RGB
// Modports: master drives the inputs (source side), slave is the detector.
interface edge_det_stream_if #(
  parameter int PIX_W = 8
);
  logic                 in_valid;
  logic                 in_sof;
  logic [3*PIX_W-1:0]   in_rgb;
  logic [1:0]           mode;
  logic [PIX_W-1:0]     thresh;
  logic                 out_valid;
  logic                 out_sof;
  logic [PIX_W-1:0]     out_edge;
  logic [3*PIX_W-1:0]   out_rgb;

  modport master (
    output in_valid, in_sof, in_rgb, mode, thresh,
    input  out_valid, out_sof, out_edge, out_rgb
  );

  modport slave (
    input  in_valid, in_sof, in_rgb, mode, thresh,
    output out_valid, out_sof, out_edge, out_rgb
  );
endinterface

// File: rtl/edge_det_stream.sv
// rtl/edge_det_stream.sv - streaming 3x3 Sobel edge detector with luma line buffers
//
// Purpose: converts each accepted RGB pixel to luma, keeps two lines of
// {Y,RGB} history, forms a 3x3 luma window and emits a thresholded gradient
// (or centre luma) together with the window-centre RGB, two clocks after
// acceptance.
// Ports:
//   clk      pixel clock, all state on rising edge
//   reset_n  asynchronous active-low reset
//   s        edge_det_stream_if.slave: in_valid/in_sof/in_rgb, mode/thresh,
//            out_valid/out_sof/out_edge/out_rgb
module edge_det_stream #(
  parameter int LINE_W = 640,
  parameter int PIX_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  edge_det_stream_if.slave s
);
  localparam int COL_W = $clog2(LINE_W);
  localparam int GW    = PIX_W + 3;   // signed gradient width
  localparam int YS_W  = PIX_W + 10;  // luma product-sum width
  localparam int LB_W  = 4 * PIX_W;   // {Y, R, G, B}
  localparam logic [GW:0] SAT_LIM = (GW+1)'((1 << PIX_W) - 1);

  // ---------------- luma ----------------
  logic [PIX_W-1:0] in_r, in_g, in_b, y_in;
  logic [YS_W-1:0]  y_sum;

  assign in_r = s.in_rgb[3*PIX_W-1:2*PIX_W];
  assign in_g = s.in_rgb[2*PIX_W-1:PIX_W];
  assign in_b = s.in_rgb[PIX_W-1:0];

  always_comb begin
    y_sum = YS_W'(54) * YS_W'(in_r) + YS_W'(183) * YS_W'(in_g) + YS_W'(18) * YS_W'(in_b);
  end
  // Coefficients sum to 255, so the top bits of the sum are always zero.
  assign y_in = y_sum[PIX_W+7:8];

  // ---------------- position counters ----------------
  // col_q/row_q hold the position the next accepted pixel will take; in_sof
  // overrides them for the pixel that carries it.
  logic [COL_W-1:0] col_q, cur_col, nxt_col;
  logic [1:0]       row_q, cur_row, nxt_row;

  always_comb begin
    cur_col = s.in_sof ? '0 : col_q;
    cur_row = s.in_sof ? '0 : row_q;
    nxt_col = cur_col + COL_W'(1);
    nxt_row = cur_row;
    if (cur_col == COL_W'(LINE_W - 1)) begin
      nxt_col = '0;
      nxt_row = (cur_row == 2'd2) ? 2'd2 : cur_row + 2'd1;
    end
  end

  // ---------------- line buffers (no reset) ----------------
  logic [LB_W-1:0] lb0 [LINE_W];
  logic [LB_W-1:0] lb1 [LINE_W];
  logic [LB_W-1:0] rd0, rd1;

  // Read-before-write: reads see the contents from before this edge.
  assign rd0 = lb0[cur_col];
  assign rd1 = lb1[cur_col];

  always_ff @(posedge clk) begin
    if (s.in_valid) begin
      lb0[cur_col] <= {y_in, s.in_rgb};
      lb1[cur_col] <= rd0;
    end
  end

  // ---------------- window and stage 1 ----------------
  // Index 0 is the oldest column, 2 the newest. Only the middle row's newest
  // RGB is kept: it becomes the window centre once the next column shifts in.
  logic [PIX_W-1:0]   w_top [3];
  logic [PIX_W-1:0]   w_mid [3];
  logic [PIX_W-1:0]   w_bot [3];
  logic [3*PIX_W-1:0] mid_rgb_new;

  logic               s1_valid, s1_sof, s1_mask;
  logic [3*PIX_W-1:0] s1_rgb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q       <= '0;
      row_q       <= '0;
      mid_rgb_new <= '0;
      for (int i = 0; i < 3; i++) begin
        w_top[i] <= '0;
        w_mid[i] <= '0;
        w_bot[i] <= '0;
      end
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_mask  <= 1'b0;
      s1_rgb   <= '0;
    end else begin
      s1_valid <= s.in_valid;
      if (s.in_valid) begin
        col_q    <= nxt_col;
        row_q    <= nxt_row;
        w_top[0] <= w_top[1];
        w_top[1] <= w_top[2];
        w_top[2] <= rd1[LB_W-1:3*PIX_W];
        w_mid[0] <= w_mid[1];
        w_mid[1] <= w_mid[2];
        w_mid[2] <= rd0[LB_W-1:3*PIX_W];
        w_bot[0] <= w_bot[1];
        w_bot[1] <= w_bot[2];
        w_bot[2] <= y_in;
        mid_rgb_new <= rd0[3*PIX_W-1:0];
        s1_sof   <= s.in_sof;
        s1_mask  <= (cur_row < 2'd2) || (cur_col < COL_W'(2));
        // Pre-shift newest middle column is the post-shift centre.
        s1_rgb   <= mid_rgb_new;
      end
    end
  end

  // ---------------- stage 2: gradients ----------------
  function automatic logic signed [GW-1:0] sx(input logic [PIX_W-1:0] v);
    return $signed({3'b000, v});
  endfunction

  logic signed [GW-1:0] gx, gy;

  always_comb begin
    gx = (sx(w_top[2]) - sx(w_top[0]))
       + ((sx(w_mid[2]) - sx(w_mid[0])) <<< 1)
       + (sx(w_bot[2]) - sx(w_bot[0]));
    gy = (sx(w_top[0]) - sx(w_bot[0]))
       + ((sx(w_top[1]) - sx(w_bot[1])) <<< 1)
       + (sx(w_top[2]) - sx(w_bot[2]));
  end

  logic                 s2_valid, s2_sof, s2_mask;
  logic [3*PIX_W-1:0]   s2_rgb;
  logic signed [GW-1:0] s2_gx, s2_gy;
  logic [PIX_W-1:0]     s2_y, s2_thresh;
  logic [1:0]           s2_mode;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_sof    <= 1'b0;
      s2_mask   <= 1'b0;
      s2_rgb    <= '0;
      s2_gx     <= '0;
      s2_gy     <= '0;
      s2_y      <= '0;
      s2_thresh <= '0;
      s2_mode   <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sof    <= s1_sof;
        s2_mask   <= s1_mask;
        s2_rgb    <= s1_rgb;
        s2_gx     <= gx;
        s2_gy     <= gy;
        s2_y      <= w_mid[1];
        s2_thresh <= s.thresh;
        s2_mode   <= s.mode;
      end
    end
  end

  // ---------------- stage 3: magnitude, threshold, mask ----------------
  logic [GW-1:0]    ax, ay;
  logic [GW:0]      sel;
  logic [PIX_W-1:0] sat_v, res;

  always_comb begin
    ax = s2_gx[GW-1] ? (~s2_gx + GW'(1)) : s2_gx;
    ay = s2_gy[GW-1] ? (~s2_gy + GW'(1)) : s2_gy;
    case (s2_mode)
      2'b01:   sel = {1'b0, ax};
      2'b10:   sel = {1'b0, ay};
      default: sel = {1'b0, ax} + {1'b0, ay};
    endcase
    sat_v = (sel > SAT_LIM) ? {PIX_W{1'b1}} : sel[PIX_W-1:0];
    if (s2_mask) begin
      res = '0;
    end else if (s2_mode == 2'b11) begin
      res = s2_y;
    end else if (sat_v <= s2_thresh) begin
      res = '0;
    end else begin
      res = sat_v;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s.out_valid <= 1'b0;
      s.out_sof   <= 1'b0;
      s.out_edge  <= '0;
      s.out_rgb   <= '0;
    end else begin
      s.out_valid <= s2_valid;
      if (s2_valid) begin
        s.out_sof  <= s2_sof;
        s.out_edge <= res;
        s.out_rgb  <= s2_rgb;
      end
    end
  end

  // RGB of the second-line history and the always-zero luma bits are unused.
  logic unused_bits;
  assign unused_bits = ^{rd1[3*PIX_W-1:0], y_sum[YS_W-1:PIX_W+8], y_sum[7:0]};
endmodule

// File: tb/tb_edge_det_stream.sv
// tb/tb_edge_det_stream.sv - randomized self-checking bench for edge_det_stream
module tb_edge_det_stream;
  localparam int LW = 8;
  localparam int PW = 8;

  typedef struct {
    int          edg;
    logic [23:0] rgb;
    bit          chk_rgb;
    bit          sof;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  edge_det_stream_if #(.PIX_W(PW)) bus ();

  edge_det_stream #(.LINE_W(LW), .PIX_W(PW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  exp_t exp_q[$];
  int got_q[$];
  logic [23:0] img [64][LW];
  int m_col = 0;
  int m_tr = 0;
  int cur_mode = 0;
  int cur_thr = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
    end
  endtask

  function automatic int luma(input logic [23:0] p);
    return (54 * int'(p[23:16]) + 183 * int'(p[15:8]) + 18 * int'(p[7:0])) / 256;
  endfunction

  // Edge result for the pixel at true row tr, column c of the current frame.
  function automatic int model_edge(input int tr, input int c);
    int y [3][3];
    int gx, gy, v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        y[i][j] = luma(img[tr-2+i][c-2+j]);
    if (cur_mode == 3) return y[1][1];
    gx = (y[0][2] - y[0][0]) + 2 * (y[1][2] - y[1][0]) + (y[2][2] - y[2][0]);
    gy = (y[0][0] - y[2][0]) + 2 * (y[0][1] - y[2][1]) + (y[0][2] - y[2][2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    v = (cur_mode == 1) ? gx : (cur_mode == 2) ? gy : gx + gy;
    if (v > 255) v = 255;
    return (v <= cur_thr) ? 0 : v;
  endfunction

  task automatic set_mode(input int m, input int t);
    cur_mode = m;
    cur_thr = t;
    bus.mode = 2'(m);
    bus.thresh = 8'(t);
  endtask

  task automatic send(input logic [23:0] rgb, input bit sof);
    exp_t e;
    if (sof) begin
      m_col = 0;
      m_tr = 0;
    end
    if (m_tr >= 64) begin
      $display("FAIL model_rows actual=%0d expected=below_64", m_tr);
      $fatal(1, "model row overflow");
    end
    img[m_tr][m_col] = rgb;
    e.edg = (m_tr < 2 || m_col < 2) ? 0 : model_edge(m_tr, m_col);
    e.chk_rgb = (m_tr >= 1 && m_col >= 1);
    e.rgb = e.chk_rgb ? img[m_tr-1][m_col-1] : 24'h0;
    e.sof = sof;
    exp_q.push_back(e);
    bus.in_valid = 1'b1;
    bus.in_sof = sof;
    bus.in_rgb = rgb;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'($urandom);
    bus.in_rgb = 24'($urandom);
    m_col++;
    if (m_col == LW) begin
      m_col = 0;
      m_tr++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // kind: 0 flat grey 100, 1 black/white step, 2 grey 100/105 step, 3 random
  function automatic logic [23:0] pix(input int kind, input int c);
    case (kind)
      0: return 24'h646464;
      1: return (c >= 4) ? 24'hFFFFFF : 24'h000000;
      2: return (c >= 4) ? 24'h696969 : 24'h646464;
      default: return {8'($urandom_range(60, 110)), 8'($urandom_range(60, 110)),
                       8'($urandom_range(60, 110))};
    endcase
  endfunction

  task automatic run_img(input int rows, input int kind, input int gaps);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < LW; c++) begin
        send(pix(kind, c), (r == 0 && c == 0));
        if (gaps != 0) idle($urandom_range(0, 3));
      end
    drain();
  endtask

  task automatic chk_outs_zero(input string name);
    chk({name, "_valid"}, int'(bus.out_valid), 0);
    chk({name, "_sof"}, int'(bus.out_sof), 0);
    chk({name, "_edge"}, int'(bus.out_edge), 0);
    chk({name, "_rgb"}, int'(bus.out_rgb), 0);
  endtask

  // Single compare process: every out_valid cycle is checked against the model.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (reset_n && bus.out_valid) begin
      n_out++;
      got_q.push_back(int'(bus.out_edge));
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("edge", int'(bus.out_edge), e.edg);
        chk("sof", int'(bus.out_sof), int'(e.sof));
        if (e.chk_rgb) chk("rgb", int'(bus.out_rgb), int'(e.rgb));
      end
    end
  end

  initial begin : main
    int n0;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_rgb = '0;
    set_mode(0, 19);

    // Model pins: hand-computed luma values.
    chk("pin_luma_white", luma(24'hFFFFFF), 254);
    chk("pin_luma_100", luma(24'h646464), 99);
    chk("pin_luma_105", luma(24'h696969), 104);

    // Reset held with in_valid toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_outs_zero("rst_hold");
      bus.in_valid = ((i % 2) == 1);
      bus.in_sof = 1'($urandom);
      bus.in_rgb = 24'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    reset_n = 1'b1;

    // Latency: a pixel accepted at E0 is visible after E2.
    send(24'h102030, 1'b0);
    @(negedge clk);
    chk("lat_after_e0", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_after_e1", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_after_e2", int'(bus.out_valid), 1);
    drain();

    // Flat field.
    n0 = n_out;
    got_q.delete();
    run_img(4, 0, 0);
    chk("flat_count", n_out - n0, 32);
    foreach (got_q[k]) chk("flat_edge_lit", got_q[k], 0);

    // Vertical step, gapless then with gaps.
    for (int g = 0; g < 2; g++) begin
      n0 = n_out;
      got_q.delete();
      run_img(5, 1, g);
      chk(g ? "gap_count" : "step_count", n_out - n0, 40);
      foreach (got_q[k])
        chk(g ? "gap_step_lit" : "step_lit", got_q[k],
            ((k / LW) >= 2 && ((k % LW) == 4 || (k % LW) == 5)) ? 255 : 0);
    end

    // Step in |Gy| mode and luma bypass.
    set_mode(2, 19);
    got_q.delete();
    run_img(5, 1, 0);
    foreach (got_q[k]) chk("step_gy_lit", got_q[k], 0);
    set_mode(3, 19);
    got_q.delete();
    run_img(5, 1, 0);
    foreach (got_q[k])
      chk("step_luma_lit", got_q[k], ((k / LW) >= 2 && (k % LW) >= 5) ? 254 : 0);

    // Threshold boundary: |Gx| = 20.
    set_mode(1, 19);
    got_q.delete();
    run_img(4, 2, 0);
    foreach (got_q[k])
      chk("thr19_lit", got_q[k],
          ((k / LW) >= 2 && ((k % LW) == 4 || (k % LW) == 5)) ? 20 : 0);
    set_mode(1, 20);
    got_q.delete();
    run_img(4, 2, 0);
    foreach (got_q[k]) chk("thr20_lit", got_q[k], 0);

    // in_sof at col 5 of row 3.
    set_mode(0, 10);
    got_q.delete();
    for (int k = 0; k < 29; k++) send(pix(3, k % LW), (k == 0));
    for (int j = 0; j < 24; j++) send(pix(3, j % LW), (j == 0));
    drain();
    for (int j = 0; j < 18; j++) chk("sof_mid_masked", got_q[29 + j], 0);

    // Reset mid-line.
    set_mode(0, 19);
    for (int k = 0; k < 20; k++) send(pix(1, k % LW), (k == 0));
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    m_col = 0;
    m_tr = 0;
    chk_outs_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    got_q.delete();
    for (int k = 0; k < 24; k++) send(pix(1, k % LW), 1'b0);
    drain();
    chk("rst_first_masked", got_q[0], 0);
    chk("rst_row2_col4", got_q[20], 255);
    chk("rst_row2_col5", got_q[21], 255);

    // Randomized runs with random gaps and occasional mid-line in_sof.
    for (int run = 0; run < 6; run++) begin
      set_mode($urandom_range(0, 3), $urandom_range(0, 60));
      for (int k = 0; k < LW * int'($urandom_range(3, 5)); k++) begin
        send(pix(3, 0), (k == 0) || ($urandom_range(0, 39) == 0));
        idle($urandom_range(0, 3));
      end
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/edge_det_stream.md
# edge_det_stream

Parametrised streaming 3×3 edge detector: the next generation of the single-mode, fixed-640, unreset Sobel stage in the camera video path. It accepts an RGB pixel stream with per-pixel valid and start-of-frame flags, and computes 8-bit luma once per pixel. It stores luma plus RGB in two line buffers, forms a 3×3 window and emits a thresholded gradient (Sobel magnitude, |Gx|, |Gy| or luma bypass) alongside the window-centre RGB. Border windows are masked, and output carries its own valid flag.

## Interface
- LINE_W, 640, active pixels per line (≥4); sets line-buffer depth and column-counter wrap
- PIX_W, 8, bits per colour channel and per luma/edge sample
- clk  in  1  pixel clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  pixel qualifier; state advances only when high
- in_sof  in  1  start of frame, meaningful only with in_valid
- in_rgb  in  3*PIX_W  {R,G,B}
- mode  in  2  00 Sobel |Gx|+|Gy|, 01 |Gx|, 10 |Gy|, 11 luma bypass
- thresh  in  PIX_W  noise floor; result ≤ thresh is forced to 0 (modes 00–10)
- out_valid  out  1  output qualifier
- out_sof  out  1  in_sof delayed with the pixel
- out_edge  out  PIX_W  edge/luma result
- out_rgb  out  3*PIX_W  RGB of window-centre pixel

## Operation
- Luma: Y = (54·R + 183·G + 18·B) >> 8. Take the 18-bit product sum and keep bits [15:8]; the result never exceeds 254.
- Counters: col runs 0..LINE_W-1. At wrap it returns to 0 and row increments, saturating at 2, so only a row ≥ 2 flag is needed. An accepted pixel with in_sof forces col = 0, row = 0 for that pixel. After reset the first accepted pixel is col 0, row 0 even without in_sof.
- Line buffers: lb0, lb1, each LINE_W × (PIX_W + 3·PIX_W) storing {Y, RGB}.
  - On acceptance at column c, read lb0[c] and lb1[c] using old data (read-before-write).
  - Then write lb0[c] ← {Y_in, in_rgb} and lb1[c] ← old lb0[c].
  - Line-buffer contents are not reset.
- Window: three 3-deep shift registers (rows: new, lb0 output, lb1 output) shift on acceptance only.
  - p0..p2 is the top (oldest) row, p6..p8 the bottom (newest) row.
  - The window centre is pixel (row−1, col−1) of the current input.
- Gradients, signed 11-bit:
  - Gx = (p2−p0) + 2(p5−p3) + (p8−p6)
  - Gy = (p0−p6) + 2(p1−p7) + (p2−p8)
- Result, by mode:
  - Mode 00: |Gx|+|Gy|, 12-bit, saturated to 255.
  - Mode 01: |Gx| saturated to 255.
  - Mode 10: |Gy| saturated to 255.
  - Apply the threshold to modes 00–10: a value ≤ thresh becomes 0.
  - Mode 11: centre luma, no threshold.
- Border mask: if the current input has row < 2 or col < 2, out_edge = 0 in every mode. out_rgb still carries the window-centre register contents.
- mode and thresh are quasi-static and sampled in stage 2. A change takes effect on the next pixel reaching stage 2; there is no frame alignment.
- No backpressure; the block cannot stall its source.

## Timing
- Stage 1 (acceptance edge E0): counters, line buffers and window update; valid, sof, mask and centre RGB are captured.
- Stage 2 (E1): Gx and Gy are registered.
- Stage 3 (E2): out_* registered.
- A pixel accepted at E0 appears with out_valid = 1 in the cycle after E2, so latency is 2 clocks.
- Stage valid bits advance every clock, whether or not in_valid is high.
- in_valid gaps do not alter results; the output sequence is identical to the gapless stream, just spaced.
- When out_valid = 0, out_edge, out_rgb and out_sof hold their last values.
- Reset values (async, immediate):
  - out_valid = 0, out_sof = 0, out_edge = 0, out_rgb = 0
  - all stage valids 0, counters 0, window registers 0
- Reset mid-frame discards in-flight pixels; no out_valid occurs until 2 clocks after the next accepted pixel.
- in_sof mid-line restarts the counters immediately. Partial-line data remaining in the buffers is masked by the row < 2 rule.

## Test plan
- Reset: hold reset_n = 0 with in_valid toggling → every output is 0. Release, send one pixel → out_valid pulses exactly 2 clocks after the acceptance edge.
- Flat field, LINE_W = 8, RGB = (100,100,100), mode 00, thresh 19, 4 lines → 32 out_valid pulses, all out_edge = 0. out_rgb equals (100,100,100) from the second line onward.
- Vertical step, LINE_W = 8, cols 0–3 = (0,0,0), cols 4–7 = (255,255,255), mode 00, thresh 19 → in rows ≥ 2, inputs at col 4 and col 5 give out_edge = 255 (Gx = 1016 saturated); all others give 0. Mode 10 → all 0. Mode 11 → luma 0 or 254 per centre column.
- Threshold boundary: window producing |Gx| = 20, Gy = 0, mode 01 → thresh 19 gives 20; thresh 20 gives 0.
- Gaps: the step stream with random in_valid gaps (up to 3 idle clocks) → out_edge sequence identical to the gapless run; out_valid count equals the input count.
- Sof and reset mid-frame: assert in_sof at col 5 of row 3 → the next two rows output 0 through col 1 of row 2. Pulse reset_n low mid-line → outputs clear immediately, and the first post-reset pixel is treated as col 0, row 0 (masked).
